// File: rtl/jogador_automatico.sv
// Automatic player: watches the game LEDs, records each newly lit value, then
// replays the recorded sequence on the button outputs after the LEDs go quiet.
module jogador_automatico #(
  parameter int T_PRESS = 10,
  parameter int T_GAP   = 10,
  parameter int T_QUIET = 1000,
  parameter int T_JOGAR = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       ganhou,
  input  logic       perdeu,
  input  logic       timeout,
  output logic       jogar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [4:0] db_quantidade
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    INICIA    = 4'd1,
    OBSERVA   = 4'd2,
    PRESSIONA = 4'd3,
    INTERVALO = 4'd4,
    FIM       = 4'd5
  } estado_t;

  localparam int TMAX0 = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
  localparam int TMAX  = (TMAX0 > T_JOGAR) ? TMAX0 : T_JOGAR;
  localparam int CW    = $clog2(TMAX + 1);
  localparam int QW    = $clog2(T_QUIET + 1);

  localparam logic [CW-1:0] JOGAR_FIM = CW'(T_JOGAR - 1);
  localparam logic [CW-1:0] PRESS_FIM = CW'(T_PRESS - 1);
  localparam logic [CW-1:0] GAP_FIM   = CW'(T_GAP - 1);
  localparam logic [QW-1:0] QUIET_MAX = QW'(T_QUIET);

  estado_t          estado;
  logic [CW-1:0]    cnt;
  logic [QW-1:0]    quieto;
  logic [3:0]       leds_ant;
  logic [3:0]       idx;
  logic [15:0][3:0] buffer;
  logic             fim_jogo;
  logic             captura;

  assign db_estado = estado;
  assign fim_jogo  = ganhou | perdeu | timeout;
  assign captura   = (leds != 4'd0) && (leds_ant == 4'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= OCIOSO;
      cnt           <= '0;
      quieto        <= '0;
      leds_ant      <= '0;
      idx           <= '0;
      buffer        <= '0;
      jogar         <= 1'b0;
      botoes        <= 4'd0;
      ocupado       <= 1'b0;
      erro          <= 1'b0;
      db_quantidade <= 5'd0;
    end else begin
      leds_ant <= leds;
      case (estado)
        OCIOSO: begin
          if (habilitar) begin
            estado        <= INICIA;
            cnt           <= '0;
            jogar         <= 1'b1;
            ocupado       <= 1'b1;
            erro          <= 1'b0;
            db_quantidade <= 5'd0;
          end
        end
        INICIA: begin
          if (cnt == JOGAR_FIM) begin
            estado        <= OBSERVA;
            jogar         <= 1'b0;
            cnt           <= '0;
            quieto        <= '0;
            db_quantidade <= 5'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OBSERVA: begin
          if (fim_jogo) begin
            estado  <= FIM;
            botoes  <= 4'd0;
            ocupado <= 1'b0;
          end else if (quieto == QUIET_MAX && db_quantidade != 5'd0) begin
            estado <= PRESSIONA;
            idx    <= 4'd0;
            cnt    <= '0;
            botoes <= buffer[0];
          end else begin
            // quiet count saturates so an empty buffer can wait forever
            if (leds != 4'd0)
              quieto <= '0;
            else if (quieto != QUIET_MAX)
              quieto <= quieto + 1'b1;
            if (captura) begin
              if (db_quantidade == 5'd16) begin
                erro <= 1'b1;
              end else begin
                buffer[db_quantidade[3:0]] <= leds;
                db_quantidade              <= db_quantidade + 5'd1;
              end
            end
          end
        end
        PRESSIONA: begin
          if (fim_jogo) begin
            estado  <= FIM;
            botoes  <= 4'd0;
            ocupado <= 1'b0;
          end else if (cnt == PRESS_FIM) begin
            estado <= INTERVALO;
            botoes <= 4'd0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INTERVALO: begin
          if (fim_jogo) begin
            estado  <= FIM;
            botoes  <= 4'd0;
            ocupado <= 1'b0;
          end else if (cnt == GAP_FIM) begin
            cnt <= '0;
            if (({1'b0, idx} + 5'd1) < db_quantidade) begin
              estado <= PRESSIONA;
              idx    <= idx + 4'd1;
              botoes <= buffer[idx + 4'd1];
            end else begin
              estado        <= OBSERVA;
              quieto        <= '0;
              db_quantidade <= 5'd0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIM: begin
          botoes <= 4'd0;
          if (!habilitar)
            estado <= OCIOSO;
        end
        default: begin
          estado  <= OCIOSO;
          jogar   <= 1'b0;
          botoes  <= 4'd0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Randomised and directed bench for jogador_automatico; the reference model keeps
// the list of newly lit LED values and derives the expected replay as run lengths.
module tb_jogador_automatico;
  localparam int T_PRESS = 10;
  localparam int T_GAP   = 10;

  logic       clock = 1'b0;
  logic       reset, habilitar, ganhou, perdeu, timeout;
  logic [3:0] leds;
  logic       jogar, ocupado, erro;
  logic [3:0] botoes, db_estado;
  logic [4:0] db_quantidade;

  int errors = 0;
  int checks = 0;

  // reference model: captured values in order, sticky overflow, last driven leds
  logic [3:0] exp_q[$];
  bit         exp_err;
  logic [3:0] prev_drv;

  jogador_automatico dut (
    .clock(clock), .reset(reset), .habilitar(habilitar), .leds(leds),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout),
    .jogar(jogar), .botoes(botoes), .ocupado(ocupado), .erro(erro),
    .db_estado(db_estado), .db_quantidade(db_quantidade)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    leds = v;
    if (v != 4'd0 && prev_drv == 4'd0) begin
      if (exp_q.size() < 16) exp_q.push_back(v);
      else exp_err = 1'b1;
    end
    prev_drv = v;
    repeat (n) tick();
  endtask

  task automatic flash(input logic [3:0] v, input int on_c, input int off_c);
    drive(v, on_c);
    drive(4'd0, off_c);
  endtask

  task automatic check_capture(input string tag);
    chk({tag, "_qtd"}, 32'(db_quantidade), 32'(exp_q.size()));
    chk({tag, "_erro"}, 32'(erro), 32'(exp_err));
  endtask

  task automatic wait_state(input logic [3:0] code, input string tag);
    int g = 0;
    while (db_estado !== code && g < 5000) begin
      tick();
      g++;
    end
    chk(tag, 32'(db_estado), 32'(code));
  endtask

  task automatic start();
    int ones = 0;
    habilitar = 1'b1;
    repeat (10) begin
      tick();
      if (jogar === 1'b1) ones++;
    end
    chk("start_jogar_cycles", 32'(ones), 32'd5);
    chk("start_estado", 32'(db_estado), 32'd2);
    chk("start_ocupado", 32'(ocupado), 32'd1);
    chk("start_qtd", 32'(db_quantidade), 32'd0);
    exp_q.delete();
    exp_err  = 1'b0;
    prev_drv = 4'd0;
  endtask

  // Record botoes while replaying, compress into (value,length) runs and
  // compare with the model: each entry pressed T_PRESS, then T_GAP of zero.
  task automatic check_replay(input string tag);
    logic [3:0] samp[$];
    logic [3:0] rv[$];
    int         rl[$];
    int         g = 0;
    bit         seen = 0;
    int         n_exp;
    while (g < 4000) begin
      if (db_estado === 4'd3 || db_estado === 4'd4) begin
        seen = 1;
        samp.push_back(botoes);
      end else if (seen) begin
        break;
      end
      tick();
      g++;
    end
    chk({tag, "_done"}, 32'((seen && g < 4000) ? 1 : 0), 32'd1);
    foreach (samp[i]) begin
      if (rv.size() > 0 && rv[rv.size()-1] === samp[i]) rl[rl.size()-1]++;
      else begin
        rv.push_back(samp[i]);
        rl.push_back(1);
      end
    end
    n_exp = 2 * exp_q.size();
    chk({tag, "_runs"}, 32'(rv.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < rv.size(); i++) begin
      logic [3:0] ev;
      ev = (i % 2 == 0) ? exp_q[i/2] : 4'd0;
      chk($sformatf("%s_val%0d", tag, i), 32'(rv[i]), 32'(ev));
      chk($sformatf("%s_len%0d", tag, i), 32'(rl[i]), 32'((i % 2 == 0) ? T_PRESS : T_GAP));
    end
    chk({tag, "_estado_after"}, 32'(db_estado), 32'd2);
    chk({tag, "_qtd_after"}, 32'(db_quantidade), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int n, sel;
    logic [3:0] v;
    reset = 1'b1; habilitar = 1'b0; leds = 4'd0;
    ganhou = 1'b0; perdeu = 1'b0; timeout = 1'b0;
    exp_err = 1'b0; prev_drv = 4'd0;
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_jogar", 32'(jogar), 32'd0);
    chk("rst_botoes", 32'(botoes), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_erro", 32'(erro), 32'd0);
    chk("rst_qtd", 32'(db_quantidade), 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    chk("idle_estado", 32'(db_estado), 32'd0);

    start();

    // single entry
    flash(4'b0001, 200, 100);
    check_capture("single");
    check_replay("single");

    // multi entry, repeated values
    flash(4'b0001, 200, 200);
    flash(4'b0001, 200, 200);
    flash(4'b0010, 200, 200);
    flash(4'b0010, 200, 200);
    flash(4'b1000, 200, 100);
    check_capture("multi");
    check_replay("multi");

    // random rounds, including nonzero-to-nonzero changes that must not capture
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(8, 1);
      for (int k = 0; k < n; k++) begin
        drive(4'($urandom_range(15, 1)), $urandom_range(6, 1));
        if ($urandom_range(1, 0) == 1) drive(4'($urandom_range(15, 1)), $urandom_range(3, 1));
        drive(4'd0, $urandom_range(10, 1));
      end
      check_capture($sformatf("rand%0d", r));
      check_replay($sformatf("rand%0d", r));
    end

    // overflow: 17 flashes, only 16 kept
    for (int k = 0; k < 17; k++) begin
      v = 4'((k % 15) + 1);
      flash(v, 200, 200);
    end
    check_capture("ovf");
    check_replay("ovf");
    chk("ovf_erro_sticky", 32'(erro), 32'(exp_err));

    // reset during replay
    flash(4'd3, 50, 50);
    flash(4'd5, 50, 50);
    check_capture("rstmid");
    wait_state(4'd3, "rstmid_press");
    chk("rstmid_pre_botoes", 32'(botoes), 32'd3);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_botoes", 32'(botoes), 32'd0);
    chk("rstmid_estado", 32'(db_estado), 32'd0);
    chk("rstmid_erro", 32'(erro), 32'd0);
    chk("rstmid_qtd", 32'(db_quantidade), 32'd0);
    chk("rstmid_ocupado", 32'(ocupado), 32'd0);
    habilitar = 1'b0;
    tick(); tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("post_rst_idle", 32'(db_estado), 32'd0);
    chk("post_rst_jogar", 32'(jogar), 32'd0);

    // end of game during replay
    start();
    flash(4'd4, 30, 30);
    flash(4'd2, 30, 30);
    check_capture("fim");
    wait_state(4'd3, "fim_press");
    chk("fim_pre_botoes", 32'(botoes), 32'd4);
    sel = $urandom_range(2, 0);
    ganhou = (sel == 0); perdeu = (sel == 1); timeout = (sel == 2);
    tick();
    chk("fim_estado", 32'(db_estado), 32'd5);
    chk("fim_botoes", 32'(botoes), 32'd0);
    chk("fim_ocupado", 32'(ocupado), 32'd0);
    ganhou = 1'b0; perdeu = 1'b0; timeout = 1'b0;
    tick();
    chk("fim_hold", 32'(db_estado), 32'd5);
    habilitar = 1'b0;
    tick();
    chk("fim_to_ocioso", 32'(db_estado), 32'd0);
    chk("fim_ocioso_jogar", 32'(jogar), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jogador_automatico.md
JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 Parameter T_PRESS, default 10: clock cycles each replayed button is held.
REQ-002 Parameter T_GAP, default 10: clock cycles of botoes=0 after each press.
REQ-003 Parameter T_QUIET, default 1000: cycles of leds==0 after the last capture that end observation.
REQ-004 Parameter T_JOGAR, default 5: cycles jogar is held high.
REQ-005 Port list:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: asynchronous, active-low.
- habilitar, input, 1: start request, level-sampled.
- leds, input, 4: game LED output being observed.
- ganhou, input, 1: game win indication.
- perdeu, input, 1: game loss indication.
- timeout, input, 1: game timeout indication.
- jogar, output, 1: game start request.
- botoes, output, 4: replayed button vector.
- ocupado, output, 1: high in every state except OCIOSO and FIM.
- erro, output, 1: capture buffer overflow flag.
- db_estado, output, 4: current state code.
- db_quantidade, output, 5: number of captured entries.

Function
REQ-006 The block SHALL implement six states, with these codes: OCIOSO=0, INICIA=1, OBSERVA=2, PRESSIONA=3, INTERVALO=4, FIM=5.
REQ-007 OCIOSO: habilitar=1 SHALL move to INICIA on the next edge.
REQ-008 INICIA SHALL drive jogar=1 for exactly T_JOGAR cycles, then enter OBSERVA with buffer count 0.
REQ-009 OBSERVA SHALL capture leds into the next buffer slot on each cycle where leds!=0 and the registered previous leds==0 (rising from zero); the non-zero value SHALL be stored as-is.
REQ-010 The buffer SHALL hold 16 entries of 4 bits; db_quantidade SHALL show entries stored (0..16).
REQ-011 A capture attempted with 16 entries stored SHALL be discarded and SHALL set erro=1 (sticky until the next INICIA or reset).
REQ-012 The quiet counter SHALL clear on any cycle with leds!=0 and increment otherwise.
REQ-013 OBSERVA SHALL go to PRESSIONA with replay index 0 when quiet counter reaches T_QUIET and count>=1.
REQ-014 With count 0, OBSERVA SHALL wait indefinitely; no quiet timeout applies.
REQ-015 PRESSIONA SHALL drive botoes=buffer[index] for exactly T_PRESS cycles, then enter INTERVALO.
REQ-016 INTERVALO SHALL drive botoes=0 for exactly T_GAP cycles, then:
- index+1 < count: increment index, go to PRESSIONA.
- otherwise: clear count, go to OBSERVA.
REQ-017 botoes SHALL be 0 in every state other than PRESSIONA.
REQ-018 jogar SHALL be 0 in every state other than INICIA.
REQ-019 ganhou, perdeu or timeout high in OBSERVA, PRESSIONA or INTERVALO SHALL force FIM on the next edge; this overrides any other transition in the same cycle.
REQ-020 FIM SHALL hold botoes=0 and SHALL return to OCIOSO when habilitar=0.
REQ-021 All outputs SHALL be registered.
REQ-022 Each full round SHALL replay the whole displayed sequence in capture order; the game is required to display the full sequence every round.
REQ-023 LED edges during PRESSIONA and INTERVALO SHALL be ignored (no capture).
REQ-024 The previous-leds register SHALL be updated every cycle, so the first cycle of OBSERVA detects an already-lit LED only if it was 0 on the prior cycle.

Reset
REQ-025 reset=0 SHALL asynchronously force the following, independent of clock:
- state OCIOSO.
- jogar=0, botoes=0, ocupado=0, erro=0.
- db_estado=0, db_quantidade=0.
- all counters and previous-leds cleared to 0.
REQ-026 reset asserted mid-replay SHALL abort immediately, with botoes=0 in the same instant.
REQ-027 After reset deasserts, no action SHALL occur until habilitar=1 is sampled on a rising edge.

Verification
REQ-028 Start: reset pulse, then habilitar=1 -> jogar=1 for exactly 5 cycles, then db_estado=2, ocupado=1.
REQ-029 Single round: leds=0001 for 200 cycles, then 0 for 1000 cycles -> botoes=0001 for exactly 10 cycles, then 0; db_quantidade returns to 0, state OBSERVA.
REQ-030 Multi-entry round: leds flashes 0001,0001,0010,0010,1000, each 200 cycles on and 200 off -> botoes pattern 0001,0001,0010,0010,1000, each 10 on and 10 off, in order.
REQ-031 Overflow: 17 flashes -> db_quantidade=16, erro=1, and only 16 entries replayed.
REQ-032 End of game: ganhou=1 during PRESSIONA -> next edge db_estado=5, botoes=0; habilitar=0 -> OCIOSO.
REQ-033 Reset mid-replay: reset=0 during PRESSIONA -> botoes=0, db_estado=0, erro=0 with no clock edge required.
